// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier.
// Each RUN cycle consumes one multiplier bit. The ripple of full-adder cells adds the
// multiplicand into the upper half of the accumulator, and the accumulator then shifts right.
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;

  // Ripple-carry chain of full-adder cells: upper accumulator half + gated multiplicand.
  always_comb begin
    logic c;
    addend = acc_q[0] ? mcand_q : '0;
    sum    = '0;
    c      = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = acc_q[WIDTH+i] ^ addend[i] ^ c;
      c      = (acc_q[WIDTH+i] & addend[i]) | (c & (acc_q[WIDTH+i] ^ addend[i]));
    end
    sum[WIDTH] = c;
  end

  // Next-state and datapath updates; the last step loads the product register on entry to DONE.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          mcand_d = a_i;
          acc_d   = {{WIDTH{1'b0}}, b_i};
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          prod_d  = {sum, acc_q[WIDTH-1:1]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that dominates start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign ready_o   = (state_q != S_RUN);
  assign done_o    = (state_q == S_DONE);
  assign product_o = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: directed cases with literal expectations plus randomized traffic,
// all compared every cycle against a cycle-count/arithmetic model of the handshake.
module tb_shift_add_mult;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_i;
  logic           start_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           ready_o;
  logic           done_o;
  logic [2*W-1:0] product_o;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: busy flag with remaining-edge count, pending product and visible outputs.
  bit          mdl_on = 0;
  bit          m_run  = 0;
  int          m_rem  = 0;
  bit          m_done = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_pend = '0;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .product_o(product_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted op finishes exactly W edges later with a*b.
  always @(posedge clk) begin
    if (rst_i) begin
      m_run  = 0;
      m_rem  = 0;
      m_done = 0;
      m_prod = '0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_rem--;
        if (m_rem == 0) begin
          m_run  = 0;
          m_prod = m_pend;
          m_done = 1;
        end
      end else if (start_i) begin
        m_run  = 1;
        m_rem  = W;
        m_pend = 32'(a_i) * 32'(b_i);
      end
    end
    mdl_on = 1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("ready", 32'(ready_o), m_run ? 32'd0 : 32'd1);
      chk("done", 32'(done_o), 32'(m_done));
      chk("product", 32'(product_o), m_prod);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(negedge clk);
    start_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
  endtask

  // Called right after issue(); checks done arrives on the (W+1)th edge counting the accept edge.
  task automatic wait_done(input logic [31:0] exp, input string nm);
    int n = 1;
    while (!done_o && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(W + 1));
    chk({nm, "_done"}, 32'(done_o), 32'd1);
    chk({nm, "_product"}, 32'(product_o), exp);
    chk({nm, "_model"}, m_prod, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b1;
    a_i     = 8'd5;
    b_i     = 8'd5;
    idle(2);
    chk("t1_ready", 32'(ready_o), 32'd1);
    chk("t1_done", 32'(done_o), 32'd0);
    chk("t1_product", 32'(product_o), 32'd0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    idle(1);
    chk("t1_still_idle", 32'(ready_o), 32'd1);

    issue(8'd13, 8'd11);  wait_done(32'h008F, "t2");
    idle(1);
    chk("t2_done_one_cycle", 32'(done_o), 32'd0);

    issue(8'd255, 8'd255); wait_done(32'hFE01, "t3a");
    issue(8'd255, 8'd1);   wait_done(32'h00FF, "t3b");
    idle(2);
    issue(8'd128, 8'd2);   wait_done(32'h0100, "t3c");

    issue(8'd0, 8'd200);   wait_done(32'h0000, "t4a");
    issue(8'd200, 8'd0);   wait_done(32'h0000, "t4b");
    issue(8'd1, 8'd1);     wait_done(32'h0001, "t4c");
    idle(3);

    // Hold start through RUN with changing operands.
    begin
      int n = 1;
      start_i = 1'b1;
      a_i = 8'd9;
      b_i = 8'd10;
      @(negedge clk);
      while (!done_o && n < 4 * W) begin
        a_i = W'($urandom);
        b_i = W'($urandom);
        @(negedge clk);
        n++;
      end
      start_i = 1'b0;
      chk("t5a_latency", 32'(n), 32'(W + 1));
      chk("t5a_product", 32'(product_o), 32'd90);
    end
    idle(2);

    // Back-to-back accept in the DONE cycle.
    issue(8'd7, 8'd9);     wait_done(32'd63, "t5b1");
    issue(8'd3, 8'd5);     wait_done(32'h000F, "t5b2");
    idle(2);

    // Reset at step 4 of an op.
    issue(8'd200, 8'd100);
    idle(3);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    chk("t6_ready", 32'(ready_o), 32'd1);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_product", 32'(product_o), 32'd0);
    idle(W + 2);
    chk("t6_no_done", 32'(product_o), 32'd0);
    issue(8'd6, 8'd7);     wait_done(32'h002A, "t6b");

    // Randomized traffic, including mid-run starts, operand churn and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_i   = ($urandom_range(0, 199) == 0);
      start_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       a_i = '0;
        1:       a_i = '1;
        default: a_i = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b_i = '0;
        1:       b_i = '1;
        default: b_i = W'($urandom);
      endcase
      @(negedge clk);
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
    idle(W + 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
